// File: rtl/sync_down_counter_pkg.sv
// Shared state encoding for sync_down_counter and its bench.
package sync_down_counter_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/dcnt_bit.sv
// One counter bit: parallel load, otherwise toggle when a borrow ripples in.
module dcnt_bit (
  input  logic clk,
  input  logic reset,
  input  logic ld,
  input  logic d,
  input  logic bin,
  output logic q,
  output logic bout
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   q <= 1'b0;
    else if (ld)  q <= d;
    else if (bin) q <= ~q;
  end

  // A bit that is 0 must borrow from the next bit up when decremented.
  assign bout = bin & ~q;

endmodule

// File: rtl/sync_down_counter.sv
// Loadable down-counter with IDLE/RUN/DONE control and registered tc pulse.
// Optional AUTO_RELOAD_EN: periodic reload from the value captured on load.
module sync_down_counter
  import sync_down_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  state_t           state, state_nxt;
  logic             ld_en;
  logic [WIDTH-1:0] ld_val;
  logic             dec_en;
  logic             tc_nxt;
  logic [WIDTH:0]   borrow;
  logic             borrow_unused;

`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    reload_q <= '0;
    else if (load) reload_q <= load_val;
  end
`endif

  always_comb begin
    state_nxt = state;
    ld_en     = 1'b0;
    ld_val    = load_val;
    dec_en    = 1'b0;
    tc_nxt    = 1'b0;
    if (load) begin
      ld_en     = 1'b1;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (q == '0) begin
              state_nxt = DONE;
              tc_nxt    = 1'b1;
            end else begin
              state_nxt = RUN;
            end
          end
        end
        RUN: begin
          if (!pause) begin
            if (q > WIDTH'(1)) begin
              dec_en = 1'b1;
            end else begin
              // q of 1 (or 0, defensively) ends the period; never decrement past 0.
              tc_nxt = 1'b1;
              ld_en  = 1'b1;
`ifdef AUTO_RELOAD_EN
              if (reload_q == '0) begin
                ld_val    = '0;
                state_nxt = DONE;
              end else begin
                ld_val = reload_q;
              end
`else
              ld_val    = '0;
              state_nxt = DONE;
`endif
            end
          end
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      tc    <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
      tc    <= tc_nxt;
    end
  end

  assign borrow[0] = dec_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dcnt_bit u_bit (
      .clk  (clk),
      .reset(reset),
      .ld   (ld_en),
      .d    (ld_val[i]),
      .bin  (borrow[i]),
      .q    (q[i]),
      .bout (borrow[i+1])
    );
  end

  // Decrement is only enabled above 1, so the top borrow never fires.
  assign borrow_unused = borrow[WIDTH];

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed vector bench for sync_down_counter (both with and without AUTO_RELOAD_EN).
module tb_sync_down_counter;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             tc;
  logic             done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_down_counter #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .load_val(load_val),
    .start   (start),
    .pause   (pause),
    .q       (q),
    .busy    (busy),
    .tc      (tc),
    .done    (done)
  );

  typedef struct {
    logic             ld;
    logic [WIDTH-1:0] lv;
    logic             st;
    logic             pz;
    logic [WIDTH-1:0] eq;
    logic             eb;
    logic             et;
    logic             ed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ld, input int lv, input logic st, input logic pz,
                              input int eq, input logic eb, input logic et, input logic ed);
    vec_t v;
    v.ld = ld; v.lv = WIDTH'(lv); v.st = st; v.pz = pz;
    v.eq = WIDTH'(eq); v.eb = eb; v.et = et; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [WIDTH-1:0] lv, input logic st, input logic pz);
    load = ld; load_val = lv; start = st; pause = pz;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input int eq, input logic eb, input logic et, input logic ed);
    chk({nm, ".q"},    32'(q),    32'(eq));
    chk({nm, ".busy"}, 32'(busy), 32'(eb));
    chk({nm, ".tc"},   32'(tc),   32'(et));
    chk({nm, ".done"}, 32'(done), 32'(ed));
  endtask

  initial begin
    int n;
    int tc_cnt;
    int bad;
    logic [WIDTH-1:0] prev;

    // ld lv st pz | q busy tc done
    vecs.push_back(mk(1, 3, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
`ifdef AUTO_RELOAD_EN
    vecs.push_back(mk(0, 0, 0, 0, 3, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0));
`else
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
`endif
    vecs.push_back(mk(1, 4, 0, 0, 4, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
`ifdef AUTO_RELOAD_EN
    vecs.push_back(mk(0, 0, 0, 0, 4, 1, 1, 0));
`else
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1));
`endif
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 5, 0, 0, 5, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 5, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk(1, 7, 1, 0, 7, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 7, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 7, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 7, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 6, 1, 0, 0));

    reset = 1'b0;
    drive(0, '0, 0, 0);
    #2;
    chk_out("reset", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk_out("post_reset", 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].pz);
      tick();
      chk_out($sformatf("v%0d", i), int'(vecs[i].eq), vecs[i].eb, vecs[i].et, vecs[i].ed);
    end

    // Asynchronous reset in the middle of a countdown at q = 5.
    drive(1, WIDTH'(5), 0, 0);
    tick();
    drive(0, '0, 1, 0);
    tick();
    chk_out("pre_async", 5, 1, 0, 0);
    drive(0, '0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk_out("rst_resume", 0, 0, 0, 0);

    // Full-scale period: exactly 15 cycles from RUN entry to tc, strictly stepping by one.
    drive(1, WIDTH'(15), 0, 0);
    tick();
    drive(0, '0, 1, 0);
    tick();
    drive(0, '0, 0, 0);
    n = 0;
    bad = 0;
    prev = q;
    while (n < 40) begin
      tick();
      n++;
      if (tc === 1'b1) break;
      if (q !== prev - WIDTH'(1)) bad++;
      prev = q;
    end
    chk("period15.len", 32'(n), 32'd15);
    chk("period15.step", 32'(bad), 32'd0);
`ifdef AUTO_RELOAD_EN
    chk_out("period15.end", 15, 1, 1, 0);

    // Periodic tc with reload value 2: pulse on every second cycle, busy never drops.
    drive(1, WIDTH'(2), 0, 0);
    tick();
    drive(0, '0, 1, 0);
    tick();
    drive(0, '0, 0, 0);
    tc_cnt = 0;
    bad = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (tc === 1'b1) tc_cnt++;
      if (tc !== ((k % 2) == 0)) bad++;
      if (busy !== 1'b1) bad++;
    end
    chk("reload2.tc_count", 32'(tc_cnt), 32'd4);
    chk("reload2.pattern", 32'(bad), 32'd0);
`else
    chk_out("period15.end", 0, 0, 1, 1);
    tick();
    chk_out("period15.hold", 0, 0, 0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/sync_down_counter.md
SYNC_DOWN_COUNTER -- requirements
Module: sync_down_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (legal range 2..16).
REQ-002 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port load, input, 1, load request: q <= load_val.
REQ-005 SHALL have port load_val, input, WIDTH, preset value.
REQ-006 SHALL have port start, input, 1, begin countdown from IDLE.
REQ-007 SHALL have port pause, input, 1, freeze q while counting.
REQ-008 SHALL have port q, output, WIDTH, current count (registered).
REQ-009 SHALL have port busy, output, 1, high while state is RUN.
REQ-010 SHALL have port tc, output, 1, one-cycle registered terminal-count pulse.
REQ-011 SHALL have port done, output, 1, high while state is DONE.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; all outputs registered.
REQ-013 Input priority SHALL be: load > start > pause > decrement.
REQ-014 load in any state SHALL set q = load_val and state = IDLE next cycle; tc = 0 that cycle.
REQ-015 IDLE with start=1, q != 0 SHALL go to RUN next cycle; q unchanged on that edge.
REQ-016 IDLE with start=1, q == 0 SHALL go to DONE with tc = 1 for one cycle.
REQ-017 RUN with pause=1 SHALL hold q and state; busy stays 1.
REQ-018 RUN with pause=0, q > 1 SHALL decrement q by 1 per cycle, modulo 2^WIDTH arithmetic, no skips.
REQ-019 RUN with pause=0, q == 1 SHALL perform the terminal transition: tc = 1 on the next cycle (same edge q leaves 1), behaviour per REQ-026/027.
REQ-020 Counting period SHALL be exactly N cycles from RUN entry to tc for load_val = N >= 1, excluding paused cycles.
REQ-021 start in RUN or DONE SHALL be ignored.
REQ-022 DONE SHALL hold q = 0 until load; tc low except on the entry cycle.
REQ-023 q SHALL never underflow through 0 to all-ones.

Reset
REQ-024 reset low SHALL immediately force state = IDLE, q = 0, busy = 0, tc = 0, done = 0, reload register = 0.
REQ-025 Deassertion mid-operation SHALL resume from IDLE with q = 0; no pending tc retained.

Configuration
REQ-026 With AUTO_RELOAD_EN defined: load SHALL also capture load_val into a reload register; terminal transition SHALL set q = reload register, pulse tc, remain in RUN (periodic tc every N cycles); if reload register == 0, go to DONE with q = 0.
REQ-027 Without AUTO_RELOAD_EN: no reload register; terminal transition SHALL set q = 0, state = DONE, pulse tc.

Structure
REQ-028 Shared package sync_down_counter_pkg SHALL hold the state enum (IDLE, RUN, DONE) and encoding constants.
REQ-029 One sub-module dcnt_bit SHALL implement a single counter bit (register plus borrow-in/borrow-out toggle logic), instantiated WIDTH times in a synchronous borrow chain; no derived clocks.

Verification
REQ-030 reset low mid-RUN at q = 5 -> q = 0, busy = 0, done = 0, tc = 0 immediately (before next clk edge).
REQ-031 load_val = 3, load, then start, no pause -> q 3,3,2,1,0; tc high exactly one cycle coincident with q = 0; done = 1 after, busy = 0 (no AUTO_RELOAD_EN).
REQ-032 load_val = 4, start, pause held 2 cycles at q = 2 -> q holds 2 for 2 cycles; tc arrives 2 cycles later than unpaused.
REQ-033 load and start asserted together with load_val = 7 while in RUN at q = 2 -> q = 7, state IDLE, busy = 0; start ignored.
REQ-034 start with q = 0 in IDLE -> next cycle done = 1, tc = 1 for one cycle, q stays 0.
REQ-035 AUTO_RELOAD_EN, load_val = 2, start -> tc every 2 cycles for >= 4 periods, busy stays 1; WIDTH = 4 load_val = 15 -> 15 cycles per period, no wrap past 0.
